// File: rtl/audio_clkgen_multi.sv
// Audio clock generator: mclk, bclk and NUM_LR word clocks from shadowed divisors, reconfigured
// only at lrclk[0] frame boundaries. Define AUDIO_CLKGEN_MULTI_TDM_EN to add the TDM frame-sync mode.
module audio_clkgen_multi #(
    parameter int NUM_LR  = 2,
    parameter int DIV_W   = 8,
    parameter int FRAME_W = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [DIV_W-1:0]          mclk_div,
    input  logic [DIV_W-1:0]          bclk_div,
    input  logic [NUM_LR*FRAME_W-1:0] lr_div,
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
    input  logic                      tdm_mode,
`endif
    output logic                      mclk,
    output logic                      bclk,
    output logic [NUM_LR-1:0]         lrclk,
    output logic                      bclk_fall,
    output logic                      running
);
    typedef enum logic [1:0] {IDLE, RUN, SWITCH, STOP} state_t;

    localparam logic [DIV_W-1:0]   MCLK_RST = '0;
    localparam logic [DIV_W-1:0]   BCLK_RST = DIV_W'(3);
    localparam logic [FRAME_W-1:0] LR_RST   = FRAME_W'(31);

    state_t                    state_q, state_d;
    logic [DIV_W-1:0]          sh_mclk_q, sh_mclk_d, sh_bclk_q, sh_bclk_d;
    logic [NUM_LR*FRAME_W-1:0] sh_lr_q, sh_lr_d;
    logic [DIV_W-1:0]          pd_mclk_q, pd_bclk_q;
    logic [NUM_LR*FRAME_W-1:0] pd_lr_q;
    logic                      pd_vld_q, pd_vld_d, pd_load;
    logic [DIV_W-1:0]          mclk_cnt_q, mclk_cnt_d, bclk_cnt_q, bclk_cnt_d;
    logic [NUM_LR*FRAME_W-1:0] lr_cnt_q, lr_cnt_d;
    logic                      mclk_q, mclk_d, bclk_q, bclk_d;
    logic                      bclk_fall_q, bclk_fall_d;
    logic [NUM_LR-1:0]         lrclk_q, lrclk_d;
    logic                      cfg_hs, fall_ev, frame_end, clear_all, frame_pol;
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
    logic                      tdm_q, tdm_d;
`endif

    assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
    assign running   = (state_q != IDLE);
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign mclk      = mclk_q;
    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign bclk_fall = bclk_fall_q;

    always_comb begin
        state_d     = state_q;
        sh_mclk_d   = sh_mclk_q;
        sh_bclk_d   = sh_bclk_q;
        sh_lr_d     = sh_lr_q;
        pd_vld_d    = pd_vld_q;
        pd_load     = 1'b0;
        mclk_cnt_d  = mclk_cnt_q;
        bclk_cnt_d  = bclk_cnt_q;
        lr_cnt_d    = lr_cnt_q;
        mclk_d      = mclk_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        bclk_fall_d = 1'b0;
        clear_all   = 1'b0;
        fall_ev     = 1'b0;
        frame_end   = 1'b0;
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
        tdm_d       = tdm_q;
        frame_pol   = tdm_q || lrclk_q[0];
`else
        frame_pol   = lrclk_q[0];
`endif

        if (state_q != IDLE) begin
            if (mclk_cnt_q == sh_mclk_q) begin
                mclk_cnt_d = '0;
                mclk_d     = ~mclk_q;
            end else begin
                mclk_cnt_d = mclk_cnt_q + DIV_W'(1);
            end

            if (bclk_cnt_q == sh_bclk_q) begin
                bclk_cnt_d = '0;
                bclk_d     = ~bclk_q;
            end else begin
                bclk_cnt_d = bclk_cnt_q + DIV_W'(1);
            end

            // Word clocks step on the same edge that drops bclk, so they change with bclk low.
            fall_ev     = bclk_q && (bclk_cnt_q == sh_bclk_q);
            bclk_fall_d = fall_ev;
            for (int i = 0; i < NUM_LR; i++) begin
                if (fall_ev) begin
                    if (lr_cnt_q[i*FRAME_W +: FRAME_W] == sh_lr_q[i*FRAME_W +: FRAME_W]) begin
                        lr_cnt_d[i*FRAME_W +: FRAME_W] = '0;
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
                        lrclk_d[i] = tdm_q ? 1'b1 : ~lrclk_q[i];
`else
                        lrclk_d[i] = ~lrclk_q[i];
`endif
                    end else begin
                        lr_cnt_d[i*FRAME_W +: FRAME_W] = lr_cnt_q[i*FRAME_W +: FRAME_W] + FRAME_W'(1);
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
                        if (tdm_q) begin
                            lrclk_d[i] = 1'b0;
                        end
`endif
                    end
                end
            end
            frame_end = fall_ev && frame_pol &&
                        (lr_cnt_q[FRAME_W-1:0] == sh_lr_q[FRAME_W-1:0]);
        end

        case (state_q)
            IDLE: begin
                clear_all = 1'b1;
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
                tdm_d     = tdm_mode;
`endif
                if (cfg_hs) begin
                    sh_mclk_d = mclk_div;
                    sh_bclk_d = bclk_div;
                    sh_lr_d   = lr_div;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cfg_hs) begin
                    pd_load  = 1'b1;
                    pd_vld_d = 1'b1;
                end
                if (!enable) begin
                    state_d = STOP;
                end else if (cfg_hs) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                if (frame_end) begin
                    clear_all = 1'b1;
                    sh_mclk_d = pd_mclk_q;
                    sh_bclk_d = pd_bclk_q;
                    sh_lr_d   = pd_lr_q;
                    pd_vld_d  = 1'b0;
                    state_d   = enable ? RUN : IDLE;
                end else if (!enable) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (frame_end) begin
                    clear_all = 1'b1;
                    if (pd_vld_q) begin
                        sh_mclk_d = pd_mclk_q;
                        sh_bclk_d = pd_bclk_q;
                        sh_lr_d   = pd_lr_q;
                    end
                    pd_vld_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Restart point: every counter and clock returns to 0 so the next RUN is frame-aligned.
        if (clear_all) begin
            mclk_cnt_d  = '0;
            bclk_cnt_d  = '0;
            lr_cnt_d    = '0;
            mclk_d      = 1'b0;
            bclk_d      = 1'b0;
            lrclk_d     = '0;
            bclk_fall_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_mclk_q   <= MCLK_RST;
            sh_bclk_q   <= BCLK_RST;
            sh_lr_q     <= {NUM_LR{LR_RST}};
            pd_vld_q    <= 1'b0;
            mclk_cnt_q  <= '0;
            bclk_cnt_q  <= '0;
            lr_cnt_q    <= '0;
            mclk_q      <= 1'b0;
            bclk_q      <= 1'b0;
            lrclk_q     <= '0;
            bclk_fall_q <= 1'b0;
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
            tdm_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sh_mclk_q   <= sh_mclk_d;
            sh_bclk_q   <= sh_bclk_d;
            sh_lr_q     <= sh_lr_d;
            pd_vld_q    <= pd_vld_d;
            mclk_cnt_q  <= mclk_cnt_d;
            bclk_cnt_q  <= bclk_cnt_d;
            lr_cnt_q    <= lr_cnt_d;
            mclk_q      <= mclk_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            bclk_fall_q <= bclk_fall_d;
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
            tdm_q       <= tdm_d;
`endif
        end
    end

    // Pending divisors are only meaningful while pd_vld_q is set, so they need no reset.
    always_ff @(posedge clk) begin
        if (pd_load) begin
            pd_mclk_q <= mclk_div;
            pd_bclk_q <= bclk_div;
            pd_lr_q   <= lr_div;
        end
    end

endmodule

// File: tb/tb_audio_clkgen_multi.sv
// Scoreboard bench for audio_clkgen_multi: stimulus queues expected observations, a negedge
// monitor measures periods/edges and output snapshots and compares them in order.
`timescale 1ns/1ps
module tb_audio_clkgen_multi;
    localparam int NUM_LR = 2;
    localparam int DIV_W = 8;
    localparam int FRAME_W = 10;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      enable = 1'b0;
    logic                      cfg_valid = 1'b0;
    logic                      cfg_ready;
    logic [DIV_W-1:0]          mclk_div = '0;
    logic [DIV_W-1:0]          bclk_div = '0;
    logic [NUM_LR*FRAME_W-1:0] lr_div = '0;
    logic                      mclk, bclk, bclk_fall, running;
    logic [NUM_LR-1:0]         lrclk;
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
    logic                      tdm_mode = 1'b0;
`endif

    audio_clkgen_multi #(.NUM_LR(NUM_LR), .DIV_W(DIV_W), .FRAME_W(FRAME_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .mclk_div  (mclk_div),
        .bclk_div  (bclk_div),
        .lr_div    (lr_div),
`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
        .tdm_mode  (tdm_mode),
`endif
        .mclk      (mclk),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .bclk_fall (bclk_fall),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef enum int {K_OUTS, K_CTRL, K_MCLK_PER, K_BCLK_PER, K_LR0_PER, K_LR1_PER,
                      K_LR0_HIGH, K_ALIGN, K_BOUNDARY} kind_t;
    typedef struct {
        string name;
        kind_t kind;
        int    want;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         busy = 1'b0;
    int         phase = 0;
    int         t0 = 0;
    int         waited = 0;
    int         cyc = 0;
    logic       mclk_p = 1'b0, bclk_p = 1'b0;
    logic [1:0] lr_p = 2'b00;
    logic       mr, br, l0r, l0f, l1r, l0c, ev;

    // Output vector {cfg_ready, running, bclk_fall, lrclk[1:0], bclk, mclk}
    function automatic int outs_vec();
        logic [6:0] v;
        v = {cfg_ready, running, bclk_fall, lrclk, bclk, mclk};
        return int'(v);
    endfunction

    task automatic check(input string nm, input int act, input int want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, want, want);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        mr  = mclk & ~mclk_p;
        br  = bclk & ~bclk_p;
        l0r = lrclk[0] & ~lr_p[0];
        l0f = ~lrclk[0] & lr_p[0];
        l1r = lrclk[1] & ~lr_p[1];
        l0c = lrclk[0] ^ lr_p[0];
        if (!busy && sb.size() > 0) begin
            cur    = sb.pop_front();
            busy   = 1'b1;
            phase  = 0;
            waited = 0;
        end
        if (busy) begin
            waited++;
            case (cur.kind)
                K_OUTS: begin
                    check(cur.name, outs_vec(), cur.want);
                    busy = 1'b0;
                end
                K_CTRL: begin
                    check(cur.name, int'({cfg_ready, running}), cur.want);
                    busy = 1'b0;
                end
                K_MCLK_PER, K_BCLK_PER, K_LR0_PER, K_LR1_PER: begin
                    ev = (cur.kind == K_MCLK_PER) ? mr :
                         (cur.kind == K_BCLK_PER) ? br :
                         (cur.kind == K_LR0_PER)  ? l0r : l1r;
                    if (ev) begin
                        if (phase == 0) begin
                            t0    = cyc;
                            phase = 1;
                        end else begin
                            check(cur.name, cyc - t0, cur.want);
                            busy = 1'b0;
                        end
                    end
                end
                K_LR0_HIGH: begin
                    if (phase == 0 && l0r) begin
                        t0    = cyc;
                        phase = 1;
                    end else if (phase == 1 && l0f) begin
                        check(cur.name, cyc - t0, cur.want);
                        busy = 1'b0;
                    end
                end
                K_ALIGN: begin
                    if (l0c) begin
                        check(cur.name, int'({bclk_fall, bclk}), cur.want);
                        busy = 1'b0;
                    end
                end
                K_BOUNDARY: begin
                    if (l0f) begin
                        check(cur.name, outs_vec(), cur.want);
                        busy = 1'b0;
                    end
                end
                default: busy = 1'b0;
            endcase
            if (busy && waited > 4000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: no DUT event within %0d cycles, expected %0d", cur.name, waited, cur.want);
                busy = 1'b0;
            end
        end
        mclk_p = mclk;
        bclk_p = bclk;
        lr_p   = lrclk;
    end

    task automatic push(input string nm, input kind_t k, input int want);
        exp_t x;
        x.name = nm;
        x.kind = k;
        x.want = want;
        sb.push_back(x);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() > 0 || busy) && w < 12000) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (w >= 12000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: scoreboard still holds %0d items, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state: IDLE, outputs low, ready high
        tick(3);
        push("reset_idle", K_OUTS, 7'b1000000);
        drain();
        reset = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        push("run_entry", K_OUTS, 7'b1100000);
        tick();
        push("first_mclk", K_OUTS, 7'b1100001);
        push("dflt_mclk_per", K_MCLK_PER, 2);
        push("dflt_bclk_per", K_BCLK_PER, 8);
        push("dflt_lr0_per", K_LR0_PER, 512);
        push("dflt_lr1_per", K_LR1_PER, 512);
        push("dflt_lr0_high", K_LR0_HIGH, 256);
        push("lr_on_bclk_fall", K_ALIGN, 2);
        drain();

        // Mid-frame reconfiguration in RUN
        cfg_valid = 1'b1;
        mclk_div  = 8'd1;
        bclk_div  = 8'd5;
        lr_div    = {10'd15, 10'd31};
        tick();
        cfg_valid = 1'b0;
        push("switch_ready_low", K_CTRL, 2'b01);
        push("switch_old_bclk", K_BCLK_PER, 8);
        push("switch_clear", K_BOUNDARY, 7'b1100000);
        push("switch_c1", K_OUTS, 7'b1100000);
        push("switch_c2", K_OUTS, 7'b1100001);
        push("switch_c3", K_OUTS, 7'b1100001);
        push("switch_c4", K_OUTS, 7'b1100000);
        push("switch_c5", K_OUTS, 7'b1100000);
        push("switch_c6", K_OUTS, 7'b1100011);
        push("new_mclk_per", K_MCLK_PER, 4);
        push("new_bclk_per", K_BCLK_PER, 12);
        push("new_lr0_per", K_LR0_PER, 768);
        push("new_lr1_per", K_LR1_PER, 384);
        drain();

        // Drop enable mid-frame
        enable = 1'b0;
        tick();
        push("stop_ctrl", K_CTRL, 2'b01);
        push("stop_bclk_per", K_BCLK_PER, 12);
        push("stop_clear", K_BOUNDARY, 7'b1000000);
        push("idle_hold_a", K_OUTS, 7'b1000000);
        push("idle_hold_b", K_OUTS, 7'b1000000);
        drain();

        // IDLE load, including a zero lrclk divisor on channel 1
        cfg_valid = 1'b1;
        mclk_div  = 8'd0;
        bclk_div  = 8'd5;
        lr_div    = {10'd0, 10'd31};
        tick();
        cfg_valid = 1'b0;
        push("idle_load_ctrl", K_CTRL, 2'b10);
        drain();
        enable = 1'b1;
        push("load_mclk_per", K_MCLK_PER, 2);
        push("load_bclk_per", K_BCLK_PER, 12);
        push("load_lr1_per_div0", K_LR1_PER, 24);
        push("load_lr0_per", K_LR0_PER, 768);
        push("load_lr0_high", K_LR0_HIGH, 384);
        drain();

        // Asynchronous reset during RUN, then defaults again
        reset = 1'b1;
        push("reset_async", K_OUTS, 7'b1000000);
        drain();
        tick(2);
        reset = 1'b0;
        push("rst_bclk_per", K_BCLK_PER, 8);
        push("rst_mclk_per", K_MCLK_PER, 2);
        push("rst_lr0_per", K_LR0_PER, 512);
        drain();

`ifdef AUDIO_CLKGEN_MULTI_TDM_EN
        enable = 1'b0;
        reset  = 1'b1;
        tick();
        reset     = 1'b0;
        tdm_mode  = 1'b1;
        cfg_valid = 1'b1;
        mclk_div  = 8'd0;
        bclk_div  = 8'd3;
        lr_div    = {10'd7, 10'd7};
        tick();
        cfg_valid = 1'b0;
        enable    = 1'b1;
        push("tdm_lr0_per", K_LR0_PER, 64);
        push("tdm_lr0_high", K_LR0_HIGH, 8);
        push("tdm_align", K_ALIGN, 2);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_clkgen_multi.md
AUDIO_CLKGEN_MULTI -- requirements
Module: audio_clkgen_multi

Interface
REQ-001 Parameter NUM_LR, default 2, number of independent LRCLK/frame-sync outputs (legal 1..4).
REQ-002 Parameter DIV_W, default 8, width of the mclk and bclk divisor fields.
REQ-003 Parameter FRAME_W, default 10, width of each per-channel LRCLK divisor field.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high (ports clk, reset).
REQ-005 clk  input  1  divider source and interface clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  level; 1 = run clocks, 0 = stop at next frame boundary.
REQ-008 cfg_valid  input  1  new divisor set offered.
REQ-009 cfg_ready  output  1  block can accept a divisor set; transfer occurs when cfg_valid & cfg_ready at a clk rising edge.
REQ-010 mclk_div  input  DIV_W  mclk period = 2*(mclk_div+1) clk cycles.
REQ-011 bclk_div  input  DIV_W  bclk period = 2*(bclk_div+1) clk cycles.
REQ-012 lr_div  input  NUM_LR*FRAME_W  channel i at [i*FRAME_W +: FRAME_W]; half-period (I2S) or frame length (TDM) = lr_div_i+1 bclk periods.
REQ-013 mclk, bclk  output  1 each  registered divided clocks.
REQ-014 lrclk  output  NUM_LR  registered word clocks / frame syncs.
REQ-015 bclk_fall  output  1  one-clk strobe in the cycle bclk goes 1->0.
REQ-016 running  output  1  1 in RUN, SWITCH, STOP.

Function
REQ-017 FSM states IDLE, RUN, SWITCH, STOP; cfg_ready = 1 only in IDLE and RUN (combinational from state).
REQ-018 Shadow registers hold active divisors; counters compare for equality against shadow only, never against live inputs.
REQ-019 IDLE: handshake writes shadow directly; all outputs 0, counters 0; enable=1 -> RUN next cycle.
REQ-020 RUN entry: counters start at 0, outputs 0; mclk toggles when mclk counter == mclk_div (first rise mclk_div+1 cycles after entry); bclk likewise with bclk_div.
REQ-021 lrclk[i] counter advances only on bclk_fall cycles; I2S mode: at a bclk_fall with count == lr_div_i, lrclk[i] toggles and count clears, in the same cycle bclk falls.
REQ-022 Frame boundary = cycle in which lrclk[0] toggles 1->0 (I2S) or its frame counter wraps (TDM).
REQ-023 RUN with handshake: divisors captured into pending register, go SWITCH; at next frame boundary pending -> shadow, all counters/outputs cleared to 0, return RUN next cycle.
REQ-024 RUN or SWITCH with enable=0: go STOP (a handshake in the same RUN cycle is still captured to pending); at next frame boundary outputs/counters cleared, pending (if valid) -> shadow, go IDLE.
REQ-025 Clocks never produce a high or low phase shorter than the programmed half-period except at the clearing edge of REQ-023/REQ-024, which occurs only at lrclk[0] low.
REQ-026 Channels i>0 are frame-aligned to channel 0 only at RUN entry; thereafter each runs on its own divisor.
REQ-027 Divisor value 0 is legal (mclk/bclk period 2 clk; lrclk half-period 1 bclk).

Reset
REQ-028 reset asserted: immediately state IDLE, all outputs 0, counters 0, pending discarded; shadow mclk_div=0, bclk_div=3, every lr_div_i=31.
REQ-029 reset mid-operation behaves identically; first RUN after release uses the REQ-028 shadow values unless reconfigured in IDLE.

Configuration
REQ-030 Macro AUDIO_CLKGEN_MULTI_TDM_EN defined: extra input tdm_mode (1 bit, sampled only in IDLE); when 1, lrclk[i] is high for exactly the first bclk period of each frame of lr_div_i+1 bclk periods, rising on the bclk_fall that starts the frame.
REQ-031 Macro undefined: no tdm_mode port, I2S 50% lrclk only, no TDM logic synthesised.

Verification
REQ-032 Reset values, enable=1: mclk period 2 clk, bclk period 8 clk, lrclk[0] period 512 clk (48 kHz at 24.576 MHz).
REQ-033 In IDLE load mclk_div=0, bclk_div=5, lr_div0=31: bclk period 12 clk, lrclk[0] period 768 clk.
REQ-034 In RUN offer new set mid-frame: cfg_ready drops next cycle; old periods persist until lrclk[0] 1->0, then all outputs 0 and new periods from next cycle; cfg_ready returns 1.
REQ-035 Drop enable mid-frame: clocks continue until lrclk[0] 1->0, then all 0, running=0; assert reset during RUN -> all outputs 0 same cycle.
REQ-036 With AUDIO_CLKGEN_MULTI_TDM_EN, tdm_mode=1, bclk_div=3, lr_div0=7: lrclk[0] high 8 clk every 64 clk, rising with bclk fall.
